inv_key_expand: RTL and testbench
=================================

INV_KEY_EXPAND -- requirements
Module: inv_key_expand

Interface
REQ-001 clk  input  1  Single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  Reset, synchronous and active-low, sampled on rising clk.
REQ-003 start  input  1  Request to begin an inverse expansion; sampled only in IDLE.
REQ-004 key_in  input  128  AES-128 round-10 key, word w0 in bits [127:96], w3 in bits [31:0].
REQ-005 busy  output  1  High in every state except IDLE.
REQ-006 rk_valid  output  1  Round key on rk_out is valid.
REQ-007 rk_ready  input  1  Consumer accepts rk_out when rk_valid and rk_ready are both high in the same cycle (handshake).
REQ-008 rk_out  output  128  Current round key, same word packing as key_in.
REQ-009 rk_round  output  4  Round index of rk_out, 10 down to 0.
REQ-010 done  output  1  One-cycle pulse after the round-0 key handshake.

Function
REQ-011 The block shall emit round keys 10, 9, ..., 0 in that order for decryption, one handshake per key.
REQ-012 The block shall use exactly one s_box instance with enc tied to 1 (forward S-box), time-shared byte-serially.
REQ-013 The FSM shall have the states IDLE, EMIT and SUB.
- IDLE: start=1 loads key_in into the key register and sets round=10; next state EMIT.
- EMIT: rk_valid=1. A handshake with round>0 goes to SUB with byte_cnt=0. A handshake with round=0 goes to IDLE and pulses done.
- SUB: runs for 4 cycles (byte_cnt 0..3); on byte_cnt=3 the key register and round update, then next state EMIT.
REQ-014 Reverse step, from current key {w0,w1,w2,w3} to the previous key {p0,p1,p2,p3}:
- p3=w3^w2, p2=w2^w1, p1=w1^w0.
- p0=w0^SubWord(RotWord(p3))^{rcon(r),24'h0}, where r is the current round.
REQ-015 rcon(r) for r=1..10 shall be 01,02,04,08,10,20,40,80,1B,36.
REQ-016 RotWord(p3) byte order shall be {p3[23:16],p3[15:8],p3[7:0],p3[31:24]}; SUB cycle k substitutes byte k of that word, MSB byte first.
REQ-017 Latency:
- start sampled in cycle T gives rk_valid=1 with round 10 in cycle T+1.
- A handshake in cycle T gives SUB in cycles T+1..T+4 and rk_valid=1 in cycle T+5.
REQ-018 While rk_valid=1 and rk_ready=0, rk_out, rk_round and rk_valid shall hold stable indefinitely.
REQ-019 rk_valid shall be 0 in IDLE and SUB.
REQ-020 rk_out and rk_round shall hold their last values outside EMIT.
REQ-021 start shall be ignored while busy=1; no restart and no reload.
REQ-022 start asserted in the same cycle that done pulses shall be ignored; a new start is accepted from the following cycle (IDLE).
REQ-023 done shall be 0 in all cycles other than the one following the round-0 handshake.
REQ-024 The key register shall change only in IDLE on start, and in SUB on byte_cnt=3.

Reset
REQ-025 rst_n=0 at a rising edge shall force IDLE and clear byte_cnt and round to 0.
REQ-026 The same reset shall clear the key register, rk_out, rk_valid, busy and done to 0.
REQ-027 Reset asserted mid-operation (EMIT or SUB) shall abandon the expansion; no further keys and no done pulse shall follow.
REQ-028 The first start shall be accepted in the first cycle with rst_n=1.

Verification
REQ-029 FIPS-197 vector, rk_ready=1 constantly:
- Stimulus: start with key_in=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Response: round 10 key equals key_in; round 9 key = ac7766f319fadc2128d12941575c006e; round 0 key = 2b7e151628aed2a6abf7158809cf4f3c.
- Response: done pulses once, one cycle after the round-0 handshake.
REQ-030 Timing, rk_ready=1 constantly: measure cycles from start to done.
- Response: 11 handshakes; done occurs 1+10*5+1 = 52 cycles after start.
REQ-031 Backpressure: rk_ready=0 for 7 cycles while rk_valid=1.
- Response: rk_out and rk_round are stable throughout; the sequence is unchanged once rk_ready returns.
REQ-032 start=1 with a different key_in pulsed during SUB and during EMIT.
- Response: ignored; output sequence identical to REQ-029.
REQ-033 Reset mid-operation: rst_n=0 during SUB of round 6, then start again.
- Response: all outputs 0 the cycle after reset; full correct sequence after the restart.
REQ-034 All-zero key_in.
- Response: round 9 key equals the reverse step of REQ-014 computed by a reference model, checked for every round through 0.

Source files
------------

// File: rtl/inv_key_expand.sv
// AES-128 inverse key expansion: streams round keys 10..0 for decryption,
// regenerating each previous key with one byte-serial forward S-box.
module s_box (
  input  logic       enc,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 through an addition chain; 0 maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x12  = gmul(gmul(x3, x3), gmul(x3, x3));
    x15  = gmul(x12, x3);
    x240 = gmul(x15, x15);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    return gmul(gmul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] a);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^
           {a[3:0], a[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] a);
    return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
  endfunction

  always_comb begin
    if (enc) dout = affine(gf_inv(din));
    else     dout = gf_inv(inv_affine(din));
  end

endmodule

module inv_key_expand (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, EMIT, SUB} state_t;

  state_t        state_q, state_d;
  logic [127:0]  key_q, key_d;
  logic [3:0]    round_q, round_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [23:0]   sub_q, sub_d;
  logic [127:0]  rk_out_q, rk_out_d;
  logic [3:0]    rk_round_q, rk_round_d;
  logic          rk_valid_q, rk_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [31:0]   w0, w1, w2, w3, p3, rot_word, sub_word, p0;
  logic [7:0]    sbox_in, sbox_out, rcon;
  logic [127:0]  prev_key;

  s_box u_sbox (
    .enc  (1'b1),
    .din  (sbox_in),
    .dout (sbox_out)
  );

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Reverse step: bytes of RotWord(p3) are substituted MSB first, one per SUB cycle.
  always_comb begin
    {w0, w1, w2, w3} = key_q;
    p3       = w3 ^ w2;
    rot_word = {p3[23:0], p3[31:24]};
    case (byte_cnt_q)
      2'd0:    sbox_in = rot_word[31:24];
      2'd1:    sbox_in = rot_word[23:16];
      2'd2:    sbox_in = rot_word[15:8];
      default: sbox_in = rot_word[7:0];
    endcase
    rcon     = rcon_of(round_q);
    sub_word = {sub_q, sbox_out};
    p0       = w0 ^ sub_word ^ {rcon, 24'h000000};
    prev_key = {p0, w1 ^ w0, w2 ^ w1, p3};
  end

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    round_d    = round_q;
    byte_cnt_d = byte_cnt_q;
    sub_d      = sub_q;
    rk_out_d   = rk_out_q;
    rk_round_d = rk_round_q;
    rk_valid_d = rk_valid_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // A start coinciding with the done pulse belongs to the finished run.
        if (start && !done_q) begin
          key_d      = key_in;
          round_d    = 4'd10;
          rk_out_d   = key_in;
          rk_round_d = 4'd10;
          rk_valid_d = 1'b1;
          state_d    = EMIT;
        end
      end
      EMIT: begin
        if (rk_valid_q && rk_ready) begin
          rk_valid_d = 1'b0;
          if (round_q == 4'd0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            byte_cnt_d = 2'd0;
            state_d    = SUB;
          end
        end
      end
      SUB: begin
        sub_d      = {sub_q[15:0], sbox_out};
        byte_cnt_d = byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd3) begin
          key_d      = prev_key;
          round_d    = round_q - 4'd1;
          rk_out_d   = prev_key;
          rk_round_d = round_q - 4'd1;
          rk_valid_d = 1'b1;
          state_d    = EMIT;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      key_q      <= '0;
      round_q    <= '0;
      byte_cnt_q <= '0;
      sub_q      <= '0;
      rk_out_q   <= '0;
      rk_round_q <= '0;
      rk_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      round_q    <= round_d;
      byte_cnt_q <= byte_cnt_d;
      sub_q      <= sub_d;
      rk_out_q   <= rk_out_d;
      rk_round_q <= rk_round_d;
      rk_valid_q <= rk_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign rk_valid = rk_valid_q;
  assign rk_out   = rk_out_q;
  assign rk_round = rk_round_q;
  assign done     = done_q;

endmodule

// File: tb/tb_inv_key_expand.sv
// Directed bench for inv_key_expand: FIPS-197 and all-zero keys checked against
// a table-driven reverse key schedule, with backpressure, ignored starts and reset abort.
module tb_inv_key_expand;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [127:0] seen_r9, seen_r0;

  localparam logic [127:0] FIPS_KEY = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [7:0] RCON [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  inv_key_expand dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_out   (rk_out),
    .rk_round (rk_round),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] rev_step(input logic [127:0] k, input int r);
    logic [31:0] w0, w1, w2, w3, p3, t;
    {w0, w1, w2, w3} = k;
    p3 = w3 ^ w2;
    t  = {SBOX[p3[23:16]], SBOX[p3[15:8]], SBOX[p3[7:0]], SBOX[p3[31:24]]} ^
         {RCON[r], 24'h000000};
    return {w0 ^ t, w1 ^ w0, w2 ^ w1, p3};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge. stall_round: round held 7 cycles with rk_ready=0 (-1 none);
  // inject: hold start high with a different key for the whole run;
  // abort_round: assert reset in the SUB following that round's handshake (-1 none).
  task automatic run_seq(input logic [127:0] key, input int stall_round, input bit inject,
                         input int abort_round, input bit chk_total);
    logic [127:0] exp;
    int c0, hs_cyc, w;
    start  = 1'b1;
    key_in = key;
    c0     = cyc;
    hs_cyc = cyc;
    exp    = key;
    @(negedge clk);
    start  = inject;
    key_in = ~key;
    for (int r = 10; r >= 0; r--) begin
      w = 0;
      while (!rk_valid && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk("latency", 128'(cyc - hs_cyc), (r == 10) ? 128'd1 : 128'd5);
      chk("rk_out", rk_out, exp);
      chk("rk_round", 128'(rk_round), 128'(r));
      if (r == 9) seen_r9 = rk_out;
      if (r == 0) seen_r0 = rk_out;
      if (r == stall_round) begin
        rk_ready = 1'b0;
        repeat (7) begin
          @(negedge clk);
          chk("stall_valid", 128'(rk_valid), 128'd1);
          chk("stall_out", rk_out, exp);
          chk("stall_round", 128'(rk_round), 128'(r));
        end
        rk_ready = 1'b1;
      end
      hs_cyc = cyc;
      @(negedge clk);
      if (r > 0) begin
        chk("sub_valid", 128'(rk_valid), 128'd0);
        chk("sub_busy", 128'(busy), 128'd1);
        if (r == abort_round) begin
          rst_n = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          start = 1'b0;
          chk("abort_out", {rk_out, rk_round, rk_valid, busy, done}, '0);
          repeat (8) begin
            @(negedge clk);
            chk("abort_quiet", 128'({rk_valid, busy, done}), 128'd0);
          end
          return;
        end
        exp = rev_step(exp, r);
      end else begin
        chk("done_pulse", 128'(done), 128'd1);
        chk("done_busy", 128'(busy), 128'd0);
        if (chk_total) chk("start_to_done", 128'(cyc - c0), 128'd52);
        @(negedge clk);
        chk("done_once", 128'(done), 128'd0);
        chk("no_restart", 128'({busy, rk_valid}), 128'd0);
        start = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    key_in   = '0;
    rk_ready = 1'b1;
    seen_r9  = '0;
    seen_r0  = '0;
    repeat (3) @(negedge clk);
    chk("reset_out", rk_out, '0);
    chk("reset_round", 128'(rk_round), 128'd0);
    chk("reset_ctl", 128'({rk_valid, busy, done}), 128'd0);

    // Start in the very first cycle out of reset.
    rst_n = 1'b1;
    run_seq(FIPS_KEY, -1, 1'b0, -1, 1'b1);
    chk("fips_r9", seen_r9, 128'hac7766f3_19fadc21_28d12941_575c006e);
    chk("fips_r0", seen_r0, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);

    repeat (2) @(negedge clk);
    run_seq(FIPS_KEY, 4, 1'b0, -1, 1'b0);
    chk("stall_r0", seen_r0, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);

    repeat (2) @(negedge clk);
    run_seq(FIPS_KEY, -1, 1'b1, -1, 1'b1);
    chk("inject_r9", seen_r9, 128'hac7766f3_19fadc21_28d12941_575c006e);
    chk("inject_r0", seen_r0, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);

    repeat (2) @(negedge clk);
    run_seq(FIPS_KEY, -1, 1'b0, 7, 1'b0);
    run_seq(FIPS_KEY, -1, 1'b0, -1, 1'b1);
    chk("restart_r0", seen_r0, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);

    repeat (2) @(negedge clk);
    run_seq(128'h0, -1, 1'b0, -1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
